// File: rtl/adjust_ctrl.sv
// adjust_ctrl: button front-end for the clock's time-setting path.
// Debounces mode/up/down, steps a field-select FSM, and emits single-cycle
// adj_up/adj_down pulses with auto-repeat and an idle timeout back to NORMAL.

// Per-button conditioner: 2-FF synchronizer followed by a stability counter.
module adjust_ctrl_deb #(
    parameter int unsigned DEB = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o
);
    localparam int unsigned CW = $clog2(DEB + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB);

    logic [1:0]    sync_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive cycles the synced value disagrees with the level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_MAX) level_d = sync_q[1];
            else                  cnt_d   = cnt_q + 1'b1;
        end
    end

    // Synchronizer, debounced level and counter state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], raw_i};
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
endmodule

module adjust_ctrl #(
    parameter logic [19:0] DEB_CYCLES    = 20'd500000,
    parameter logic [24:0] REPEAT_DELAY  = 25'd25000000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd5000000,
    parameter logic [4:0]  TIMEOUT_S     = 5'd30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       t_1s,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       adj_en,
    output logic [5:0] adj_sel,
    output logic       adj_up,
    output logic       adj_down,
    output logic [2:0] mode_state
);
    localparam logic [2:0] S_NORMAL = 3'd0;
    localparam logic [2:0] S_SEC    = 3'd1;
    localparam logic [2:0] S_MIN    = 3'd2;
    localparam logic [2:0] S_HOUR   = 3'd3;
    localparam logic [2:0] S_DAY    = 3'd4;
    localparam logic [2:0] S_MON    = 3'd5;
    localparam logic [2:0] S_YEAR   = 3'd6;

    localparam int unsigned HW = $clog2(32'(REPEAT_DELAY) + 1);
    localparam int unsigned RW = $clog2(32'(REPEAT_PERIOD) + 1);
    localparam int unsigned TW = $clog2(32'(TIMEOUT_S) + 1);
    localparam logic [HW-1:0] HOLD_SAT  = HW'(32'(REPEAT_DELAY));
    localparam logic [HW-1:0] HOLD_LAST = HW'(32'(REPEAT_DELAY) - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(32'(REPEAT_PERIOD) - 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(32'(TIMEOUT_S) - 1);

    // Button index: 0 = mode, 1 = up, 2 = down.
    logic [2:0] raw, lvl, lvl_prev_q, rise;
    assign raw = {btn_down, btn_up, btn_mode};

    for (genvar b = 0; b < 3; b++) begin : g_deb
        adjust_ctrl_deb #(.DEB(32'(DEB_CYCLES))) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw_i   (raw[b]),
            .level_o (lvl[b])
        );
    end

    assign rise = lvl & ~lvl_prev_q;

    logic [2:0]    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [RW-1:0] rep_q, rep_d;
    logic [TW-1:0] idle_q, idle_d;
    logic          armed_q, armed_d;
    logic          up_d, dn_d;
    logic          en_q;
    logic [5:0]    sel_q, sel_d;
    logic          up_q, dn_q;
    logic          press_any, one_held;

    assign press_any = rise[1] | rise[2];
    assign one_held  = lvl[1] ^ lvl[2];

    // Mode FSM, step/repeat generation and idle timeout. Repeat is armed only
    // by a step pulse in the current field, so a button carried across a mode
    // change or left over from a both-held chord never auto-repeats.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        rep_d   = rep_q;
        idle_d  = idle_q;
        armed_d = armed_q;
        up_d    = 1'b0;
        dn_d    = 1'b0;
        if (state_q == S_NORMAL) begin
            hold_d  = '0;
            rep_d   = '0;
            idle_d  = '0;
            armed_d = 1'b0;
            if (rise[0]) state_d = S_SEC;
        end else if (rise[0]) begin
            state_d = (state_q == S_YEAR) ? S_NORMAL : state_q + 3'd1;
            hold_d  = '0;
            rep_d   = '0;
            idle_d  = '0;
            armed_d = 1'b0;
        end else begin
            if (press_any) begin
                hold_d  = '0;
                rep_d   = '0;
                idle_d  = '0;
                armed_d = one_held;
                up_d    = rise[1] & one_held;
                dn_d    = rise[2] & one_held;
            end else if (!one_held || !armed_q) begin
                hold_d  = '0;
                rep_d   = '0;
                armed_d = 1'b0;
            end else if (hold_q != HOLD_SAT) begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HOLD_LAST) begin
                    up_d = lvl[1];
                    dn_d = lvl[2];
                end
            end else begin
                if (rep_q == REP_LAST) begin
                    rep_d = '0;
                    up_d  = lvl[1];
                    dn_d  = lvl[2];
                end else begin
                    rep_d = rep_q + 1'b1;
                end
            end
            // A press in the same cycle cancels the expiring tick.
            if (!press_any && t_1s) begin
                if (idle_q == IDLE_LAST) begin
                    state_d = S_NORMAL;
                    idle_d  = '0;
                    hold_d  = '0;
                    rep_d   = '0;
                    armed_d = 1'b0;
                    up_d    = 1'b0;
                    dn_d    = 1'b0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
        end
    end

    // One-hot field select decoded from the next state so it tracks mode_state.
    always_comb begin
        sel_d = 6'b000000;
        case (state_d)
            S_SEC:   sel_d = 6'b000001;
            S_MIN:   sel_d = 6'b000010;
            S_HOUR:  sel_d = 6'b000100;
            S_DAY:   sel_d = 6'b001000;
            S_MON:   sel_d = 6'b010000;
            S_YEAR:  sel_d = 6'b100000;
            default: sel_d = 6'b000000;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lvl_prev_q <= '0;
            state_q    <= S_NORMAL;
            hold_q     <= '0;
            rep_q      <= '0;
            idle_q     <= '0;
            armed_q    <= 1'b0;
            en_q       <= 1'b0;
            sel_q      <= '0;
            up_q       <= 1'b0;
            dn_q       <= 1'b0;
        end else begin
            lvl_prev_q <= lvl;
            state_q    <= state_d;
            hold_q     <= hold_d;
            rep_q      <= rep_d;
            idle_q     <= idle_d;
            armed_q    <= armed_d;
            en_q       <= (state_d != S_NORMAL);
            sel_q      <= sel_d;
            up_q       <= up_d;
            dn_q       <= dn_d;
        end
    end

    assign mode_state = state_q;
    assign adj_en     = en_q;
    assign adj_sel    = sel_q;
    assign adj_up     = up_q;
    assign adj_down   = dn_q;
endmodule
